// File: rtl/reg_dest_scoreboard.sv
// Destination-register scoreboard: per-register in-flight write counters, RAW stall for decode sources.
// Latency: reservation/release visible one cycle after issue/wb; SCOREBOARD_WB_BYPASS_EN makes wb releases same-cycle.
// Backpressure: issue_ready drops while issue_dest's counter is saturated; a dropped issue must be held upstream.
module reg_dest_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   src_a,
    input  logic [ADDR_W-1:0]   src_b,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] count_q;
    logic [NUM_REGS-1:0][CNT_W-1:0] count_d;
    logic [NUM_REGS-1:0]            busy_d;
    logic                           issue_accept;
    logic                           wb_live;
    logic                           uf_set;
    logic                           src_a_pend;
    logic                           src_b_pend;

    // Register 0 is hardwired: writebacks to it neither release nor underflow.
    assign wb_live = wb_valid && (wb_dest != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    logic wb_hits_issue;
    logic wb_rel_a;
    logic wb_rel_b;

    // A retiring last write is forwarded by the register file, so it no longer blocks this cycle.
    assign wb_hits_issue = wb_live && (wb_dest == issue_dest);
    assign wb_rel_a      = wb_live && (wb_dest == src_a) && (count_q[src_a] == CNT_ONE);
    assign wb_rel_b      = wb_live && (wb_dest == src_b) && (count_q[src_b] == CNT_ONE);

    assign issue_ready = (issue_dest == '0) || (count_q[issue_dest] != CNT_MAX) || wb_hits_issue;
    assign src_a_pend  = (src_a != '0) && (count_q[src_a] != '0) && !wb_rel_a;
    assign src_b_pend  = (src_b != '0) && (count_q[src_b] != '0) && !wb_rel_b;
`else
    assign issue_ready = (issue_dest == '0) || (count_q[issue_dest] != CNT_MAX);
    assign src_a_pend  = (src_a != '0) && (count_q[src_a] != '0);
    assign src_b_pend  = (src_b != '0) && (count_q[src_b] != '0);
`endif

    assign stall        = src_a_pend || src_b_pend;
    assign issue_accept = issue_valid && issue_ready && (issue_dest != '0);

    always_comb begin
        logic inc;
        logic dec;
        count_d = count_q;
        uf_set  = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc = issue_accept && (issue_dest == ADDR_W'(r));
            dec = wb_live && (wb_dest == ADDR_W'(r));
            case ({inc, dec})
                2'b10: count_d[r] = count_q[r] + CNT_ONE;
                2'b01: begin
                    if (count_q[r] != '0) begin
                        count_d[r] = count_q[r] - CNT_ONE;
                    end else begin
                        uf_set = 1'b1;
                    end
                end
                default: count_d[r] = count_q[r];
            endcase
        end
        // Flush discards this cycle's issue and wb entirely, including any underflow they imply.
        if (flush) begin
            count_d = '0;
            uf_set  = 1'b0;
        end
    end

    always_comb begin
        busy_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = (count_d[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q       <= '0;
            busy_mask     <= '0;
            underflow_err <= 1'b0;
        end else begin
            count_q   <= count_d;
            busy_mask <= busy_d;
            if (uf_set) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Self-checking bench for reg_dest_scoreboard: directed scenarios plus randomized traffic vs a counter-array model.
module tb_reg_dest_scoreboard;

    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int CMAX = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic [AW-1:0] issue_dest;
    logic          issue_ready;
    logic          wb_valid;
    logic [AW-1:0] wb_dest;
    logic          flush;
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    logic          stall;
    logic [NR-1:0] busy_mask;
    logic          underflow_err;

    int m_cnt[NR];
    bit m_uf;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_dest_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .flush        (flush),
        .src_a        (src_a),
        .src_b        (src_b),
        .stall        (stall),
        .busy_mask    (busy_mask),
        .underflow_err(underflow_err)
    );

    // Reference model: one integer counter per register, updated from the rules directly.
    function automatic bit m_ready();
        if (issue_dest == 0) return 1'b1;
        if (m_cnt[issue_dest] < CMAX) return 1'b1;
        return BYP && wb_valid && (wb_dest == issue_dest);
    endfunction

    function automatic bit m_pend(input logic [AW-1:0] s);
        if (s == 0) return 1'b0;
        if (m_cnt[s] == 0) return 1'b0;
        if (BYP && wb_valid && (wb_dest == s) && (m_cnt[s] == 1)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NR-1:0] m_busy();
        logic [NR-1:0] b;
        for (int i = 0; i < NR; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic cycle();
        int nxt[NR];
        bit nuf;
        bit acc;
        nxt = m_cnt;
        nuf = m_uf;
        acc = issue_valid && m_ready() && (issue_dest != 0);
        if (!rst_n) begin
            foreach (nxt[i]) nxt[i] = 0;
            nuf = 1'b0;
        end else if (flush) begin
            foreach (nxt[i]) nxt[i] = 0;
        end else if (!(acc && wb_valid && wb_dest == issue_dest)) begin
            if (acc) nxt[issue_dest] = nxt[issue_dest] + 1;
            if (wb_valid && wb_dest != 0) begin
                if (nxt[wb_dest] == 0) nuf = 1'b1;
                else nxt[wb_dest] = nxt[wb_dest] - 1;
            end
        end
        @(posedge clk);
        m_cnt = nxt;
        m_uf  = nuf;
        #2;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_dest  = '0;
        wb_valid    = 1'b0;
        wb_dest     = '0;
        flush       = 1'b0;
        src_a       = '0;
        src_b       = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        cycle();
        cycle();
        n_checks++;
        if (busy_mask !== '0) begin
            n_fail++;
            $display("FAIL reset_busy: got %h want 0", busy_mask);
        end
        n_checks++;
        if (underflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_uf: got %b want 0", underflow_err);
        end
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        src_a       = 5'd5;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", issue_ready);
        end
    endtask

    task automatic test_basic_raw();
        idle();
        issue_valid = 1'b1;
        issue_dest  = 5'd8;
        cycle();
        idle();
        src_a = 5'd8;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_checks++;
            if (stall !== 1'b1 || busy_mask[8] !== 1'b1) begin
                n_fail++;
                $display("FAIL raw_pending c%0d: stall=%b busy8=%b want 1/1", c, stall, busy_mask[8]);
            end
            cycle();
        end
        wb_valid = 1'b1;
        wb_dest  = 5'd8;
        #1;
        n_checks++;
        if (stall !== !BYP || busy_mask[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_wb_cycle: stall=%b busy8=%b want %b/1", stall, busy_mask[8], !BYP);
        end
        cycle();
        wb_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || busy_mask[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_released: stall=%b busy8=%b want 0/0", stall, busy_mask[8]);
        end
    endtask

    task automatic test_saturation();
        idle();
        issue_valid = 1'b1;
        issue_dest  = 5'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (issue_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_ready_%0d: got %b want 1", k, issue_ready);
            end
            cycle();
        end
        #1;
        n_checks++;
        if (issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_full: got %b want 0", issue_ready);
        end
        cycle();
        issue_valid = 1'b0;
        wb_valid    = 1'b1;
        wb_dest     = 5'd3;
        cycle();
        wb_valid = 1'b0;
        src_a    = 5'd3;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_after_wb: ready=%b stall=%b want 1/1", issue_ready, stall);
        end
        wb_valid = 1'b1;
        cycle();
        #1;
        n_checks++;
        if (busy_mask[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_dropped: busy3=%b want 1 (one write left)", busy_mask[3]);
        end
        cycle();
        wb_valid = 1'b0;
        #1;
        n_checks++;
        if (busy_mask[3] !== 1'b0 || underflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_drain: busy3=%b uf=%b want 0/0", busy_mask[3], underflow_err);
        end
    endtask

    task automatic test_simultaneous();
        idle();
        issue_valid = 1'b1;
        issue_dest  = 5'd9;
        cycle();
        wb_valid = 1'b1;
        wb_dest  = 5'd9;
        src_b    = 5'd9;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1 || stall !== !BYP) begin
            n_fail++;
            $display("FAIL simul_same_cycle: ready=%b stall=%b want 1/%b", issue_ready, stall, !BYP);
        end
        cycle();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1 || busy_mask[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_held: stall=%b busy9=%b want 1/1", stall, busy_mask[9]);
        end
        wb_valid = 1'b1;
        cycle();
        wb_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || busy_mask !== '0) begin
            n_fail++;
            $display("FAIL simul_drain: stall=%b busy=%h want 0/0", stall, busy_mask);
        end
    endtask

    task automatic test_reg_zero_underflow();
        idle();
        issue_valid = 1'b1;
        issue_dest  = 5'd0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %b want 1", issue_ready);
        end
        cycle();
        idle();
        wb_valid = 1'b1;
        wb_dest  = 5'd0;
        cycle();
        wb_valid = 1'b0;
        #1;
        n_checks++;
        if (busy_mask !== '0 || stall !== 1'b0 || underflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_ignored: busy=%h stall=%b uf=%b want 0/0/0", busy_mask, stall, underflow_err);
        end
        wb_valid = 1'b1;
        wb_dest  = 5'd12;
        cycle();
        idle();
        cycle();
        cycle();
        #1;
        n_checks++;
        if (underflow_err !== 1'b1 || busy_mask[12] !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_sticky: uf=%b busy12=%b want 1/0", underflow_err, busy_mask[12]);
        end
    endtask

    task automatic test_flush();
        idle();
        issue_valid = 1'b1;
        issue_dest  = 5'd4;
        cycle();
        issue_dest = 5'd7;
        cycle();
        cycle();
        #1;
        n_checks++;
        if (busy_mask !== 32'h0000_0090) begin
            n_fail++;
            $display("FAIL flush_pre: busy=%h want 00000090", busy_mask);
        end
        flush      = 1'b1;
        issue_dest = 5'd10;
        cycle();
        idle();
        src_a = 5'd4;
        src_b = 5'd10;
        #1;
        n_checks++;
        if (busy_mask !== '0 || stall !== 1'b0 || underflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_post: busy=%h stall=%b uf=%b want 0/0/1", busy_mask, stall, underflow_err);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 600; it++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_dest  = AW'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_dest     = AW'($urandom_range(0, 7));
            src_a       = AW'($urandom_range(0, 8));
            src_b       = ($urandom_range(0, 3) == 0) ? wb_dest : AW'($urandom_range(0, 8));
            #1;
            n_checks++;
            if (issue_ready !== m_ready() || stall !== (m_pend(src_a) | m_pend(src_b))) begin
                n_fail++;
                $display("FAIL rand_comb it%0d: ready=%b stall=%b want %b/%b", it, issue_ready, stall,
                         m_ready(), m_pend(src_a) | m_pend(src_b));
            end
            cycle();
            n_checks++;
            if (busy_mask !== m_busy() || underflow_err !== m_uf) begin
                n_fail++;
                $display("FAIL rand_state it%0d: busy=%h uf=%b want %h/%b", it, busy_mask, underflow_err,
                         m_busy(), m_uf);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_uf  = 1'b0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_basic_raw();
        test_saturation();
        test_simultaneous();
        test_reg_zero_underflow();
        test_flush();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
